azimuth_signal_generator_mc: RTL and testbench

- Multi-channel, double-buffered successor of the serial azimuth pattern generator.
- Per channel, shifts out a SIZE-bit azimuth pattern one bit per CLK_PE tick, restarting on each TRIG.
- A shadow buffer is loaded via a valid/ready handshake and swapped in on TRIG, so a new sweep pattern never tears mid-sweep.
- Sits after the edge_detect stages on the US clock and trigger; drives the per-channel simulated radar outputs.

---
 rtl/azimuth_gen_pkg.sv | 15 +
 rtl/azimuth_shadow_buffer.sv | 51 +++++
 rtl/azimuth_signal_generator_mc.sv | 132 +++++++++++++
 tb/tb_azimuth_signal_generator_mc.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/azimuth_gen_pkg.sv
// Shared types and helpers for the multi-channel azimuth generator.
// Sequencer state and bit-index width helper.
package azimuth_gen_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Index must be able to hold SIZE itself (end-of-sweep marker).
    function automatic int idx_w(input int size);
        return $clog2(size + 1);
    endfunction

endpackage

// File: rtl/azimuth_shadow_buffer.sv
// Shadow pattern register with valid/ready load handshake.
// Emptied by a swap strobe when the sequencer takes the pattern.
module azimuth_shadow_buffer
    import azimuth_gen_pkg::*;
#(
    parameter int CH   = 2,
    parameter int SIZE = 3200
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_valid,
    input  logic [CH*SIZE-1:0] load_data,
    input  logic               swap,
    output logic               load_ready,
    output logic               valid,
    output logic [CH*SIZE-1:0] data
);

    logic               valid_q;
    logic               valid_d;
    logic [CH*SIZE-1:0] data_q;
    logic [CH*SIZE-1:0] data_d;

    // Swap only happens when full, load only when empty: never both.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (swap) begin
            valid_d = 1'b0;
        end else if (load_valid && !valid_q) begin
            data_d  = load_data;
            valid_d = 1'b1;
        end
    end

    // Shadow state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign load_ready = !valid_q;
    assign valid      = valid_q;
    assign data       = data_q;

endmodule

// File: rtl/azimuth_signal_generator_mc.sv
// Multi-channel double-buffered azimuth pattern generator.
// Shifts SIZE bits per channel per sweep, restarting on TRIG.
module azimuth_signal_generator_mc
    import azimuth_gen_pkg::*;
#(
    parameter int SIZE  = 3200,
    parameter int CH    = 2,
    parameter int IDX_W = idx_w(SIZE)
) (
    input  logic               SYS_CLK,
    input  logic               SYS_RESETN,
    input  logic               EN,
    input  logic               TRIG,
    input  logic               CLK_PE,
    input  logic               MODE,
    input  logic               LOAD_VALID,
    output logic               LOAD_READY,
    input  logic [CH*SIZE-1:0] DATA,
    output logic [CH-1:0]      GEN_SIGNAL,
    output logic               BUSY,
    output logic               UNDERRUN,
    output logic [IDX_W-1:0]   BIT_IDX
);

    localparam logic [IDX_W-1:0] IDX_END = IDX_W'(SIZE);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    state_e             state_q;
    state_e             state_d;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   idx_d;
    logic [CH-1:0]      gen_q;
    logic [CH-1:0]      gen_d;
    logic               underrun_q;
    logic               underrun_d;
    logic [CH*SIZE-1:0] active_q;
    logic [CH*SIZE-1:0] active_d;
    logic               active_valid_q;
    logic               active_valid_d;

    logic               swap;
    logic               shadow_valid;
    logic [CH*SIZE-1:0] shadow_data;
    logic [CH*SIZE-1:0] cur;

    azimuth_shadow_buffer #(
        .CH   (CH),
        .SIZE (SIZE)
    ) u_shadow (
        .clk        (SYS_CLK),
        .rst_n      (SYS_RESETN),
        .load_valid (LOAD_VALID),
        .load_data  (DATA),
        .swap       (swap),
        .load_ready (LOAD_READY),
        .valid      (shadow_valid),
        .data       (shadow_data)
    );

    // Sequencer: TRIG beats CLK_PE; bit k of channel c sits at c*SIZE+k.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        gen_d          = gen_q;
        underrun_d     = 1'b0;
        active_d       = active_q;
        active_valid_d = active_valid_q;
        swap           = 1'b0;
        cur            = active_q >> idx_q;
        if (!EN) begin
            state_d = IDLE;
            gen_d   = '0;
            idx_d   = '0;
        end else if (TRIG) begin
            gen_d = '0;
            idx_d = '0;
            if (shadow_valid) begin
                swap           = 1'b1;
                active_d       = shadow_data;
                active_valid_d = 1'b1;
                state_d        = RUN;
            end else if (active_valid_q) begin
                underrun_d = 1'b1;
                state_d    = RUN;
            end else begin
                underrun_d = 1'b1;
                state_d    = IDLE;
            end
        end else if (CLK_PE && state_q == RUN) begin
            if (idx_q < IDX_END) begin
                for (int c = 0; c < CH; c++) begin
                    gen_d[c] = cur[c*SIZE];
                end
                idx_d = idx_q + IDX_ONE;
            end else if (!MODE) begin
                gen_d   = '0;
                idx_d   = '0;
                state_d = IDLE;
            end else begin
                for (int c = 0; c < CH; c++) begin
                    gen_d[c] = active_q[c*SIZE];
                end
                idx_d = IDX_ONE;
            end
        end
    end

    // Sequencer and output registers.
    always_ff @(posedge SYS_CLK or negedge SYS_RESETN) begin
        if (!SYS_RESETN) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            gen_q          <= '0;
            underrun_q     <= 1'b0;
            active_q       <= '0;
            active_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            gen_q          <= gen_d;
            underrun_q     <= underrun_d;
            active_q       <= active_d;
            active_valid_q <= active_valid_d;
        end
    end

    assign GEN_SIGNAL = gen_q;
    assign BUSY       = (state_q == RUN);
    assign UNDERRUN   = underrun_q;
    assign BIT_IDX    = idx_q;

endmodule

// File: tb/tb_azimuth_signal_generator_mc.sv
// Bench for azimuth_signal_generator_mc (SIZE=8, CH=2).
// Directed plan plus randomized traffic against a sweep-position model.
module tb_azimuth_signal_generator_mc;

    localparam int SIZE = 8;
    localparam int CH   = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic        trig = 1'b0;
    logic        pe = 1'b0;
    logic        mode = 1'b0;
    logic        lv = 1'b0;
    logic        lr;
    logic [15:0] data = '0;
    logic [1:0]  gen;
    logic        busy;
    logic        under;
    logic [3:0]  bidx;

    int n_checks = 0;
    int n_fail = 0;

    bit [15:0] m_shadow;
    bit [15:0] m_active;
    bit        m_sv;
    bit        m_av;
    bit        m_run;
    int        m_pos;
    bit [1:0]  m_gen;
    bit        m_under;
    int        m_idx;

    azimuth_signal_generator_mc #(
        .SIZE (SIZE),
        .CH   (CH)
    ) dut (
        .SYS_CLK    (clk),
        .SYS_RESETN (rst_n),
        .EN         (en),
        .TRIG       (trig),
        .CLK_PE     (pe),
        .MODE       (mode),
        .LOAD_VALID (lv),
        .LOAD_READY (lr),
        .DATA       (data),
        .GEN_SIGNAL (gen),
        .BUSY       (busy),
        .UNDERRUN   (under),
        .BIT_IDX    (bidx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d",
                     nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_shadow = '0;
        m_active = '0;
        m_sv     = 0;
        m_av     = 0;
        m_run    = 0;
        m_pos    = 0;
        m_gen    = '0;
        m_under  = 0;
        m_idx    = 0;
    endtask

    // Model in terms of "how many CLK_PE since TRIG".
    task automatic model_step();
        bit old_sv;
        int b;
        old_sv  = m_sv;
        m_under = 0;
        if (!en) begin
            m_run = 0;
            m_gen = '0;
            m_idx = 0;
        end else if (trig) begin
            m_gen = '0;
            m_idx = 0;
            m_pos = 0;
            if (m_sv) begin
                m_active = m_shadow;
                m_av     = 1;
                m_sv     = 0;
                m_run    = 1;
            end else begin
                m_under = 1;
                m_run   = m_av;
            end
        end else if (pe && m_run) begin
            if (m_pos >= SIZE && (m_pos % SIZE) == 0 && !mode) begin
                m_run = 0;
                m_gen = '0;
                m_idx = 0;
            end else begin
                b = m_pos % SIZE;
                for (int c = 0; c < CH; c++)
                    m_gen[c] = m_active[c*SIZE + b];
                m_idx = b + 1;
                m_pos++;
            end
        end
        if (lv && !old_sv) begin
            m_shadow = data;
            m_sv     = 1;
        end
    endtask

    // Single compare process: model advances, then outputs are checked.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
        #1;
        chk("gen_signal", gen, m_gen);
        chk("busy", busy, m_run);
        chk("underrun", under, m_under);
        chk("bit_idx", bidx, m_idx);
        chk("load_ready", lr, !m_sv);
    end

    task automatic step(input bit t, input bit p, input bit l);
        @(negedge clk);
        trig = t;
        pe   = p;
        lv   = l;
        @(posedge clk);
        #2;
    endtask

    logic [7:0] ch0;
    logic [7:0] ch1;

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_gen", gen, 0);
        chk("rst_ready", lr, 1);
        chk("rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b1;

        // One-shot sweep.
        en   = 1'b1;
        mode = 1'b0;
        data = 16'hA50F;
        step(0, 0, 1);
        chk("lit_loaded_ready", lr, 0);
        step(1, 0, 0);
        chk("lit_trig_busy", busy, 1);
        chk("lit_trig_under", under, 0);
        chk("lit_swap_ready", lr, 1);
        for (int k = 0; k < 8; k++) begin
            step(0, 1, 0);
            ch0[k] = gen[0];
            ch1[k] = gen[1];
        end
        chk("lit_ch0_pattern", ch0, 8'h0F);
        chk("lit_ch1_pattern", ch1, 8'hA5);
        step(0, 1, 0);
        chk("lit_end_gen", gen, 0);
        chk("lit_end_busy", busy, 0);

        // Continuous sweep with mid-sweep load.
        mode = 1'b1;
        step(0, 0, 1);
        step(1, 0, 0);
        for (int k = 0; k < 17; k++) begin
            if (k == 3) begin
                data = 16'h3CC3;
                step(0, 1, 1);
            end else begin
                step(0, 1, 0);
            end
            if (k == 3) chk("lit_midload_gen", gen, 2'b01);
            if (k == 8) begin
                chk("lit_wrap_gen", gen, 2'b11);
                chk("lit_wrap_idx", bidx, 1);
            end
        end
        step(1, 0, 0);
        chk("lit_swap2_under", under, 0);
        step(1, 0, 0);
        chk("lit_replay_under", under, 1);
        chk("lit_replay_busy", busy, 1);
        step(0, 0, 0);
        chk("lit_under_pulse", under, 0);

        // TRIG and CLK_PE together.
        step(1, 1, 0);
        chk("lit_tp_idx", bidx, 0);
        chk("lit_tp_gen", gen, 0);
        step(0, 1, 0);
        chk("lit_tp_bit0", gen, 2'b01);

        // EN drop at BIT_IDX=3.
        step(0, 1, 0);
        step(0, 1, 0);
        chk("lit_idx3", bidx, 3);
        en = 1'b0;
        step(0, 1, 0);
        chk("lit_en_gen", gen, 0);
        chk("lit_en_idx", bidx, 0);
        en = 1'b1;
        step(1, 0, 0);
        step(0, 1, 0);
        chk("lit_en_restart", gen, 2'b01);

        // Async reset mid-sweep with a pending shadow.
        step(0, 1, 0);
        data = 16'h1234;
        step(0, 0, 1);
        chk("lit_pending", lr, 0);
        @(negedge clk);
        lv = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("lit_arst_gen", gen, 0);
        chk("lit_arst_ready", lr, 1);
        chk("lit_arst_busy", busy, 0);
        #1 rst_n = 1'b1;
        step(1, 0, 0);
        chk("lit_post_under", under, 1);
        chk("lit_post_busy", busy, 0);
        step(0, 1, 0);
        chk("lit_post_gen", gen, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(399) == 0) begin
                #1 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            en   = ($urandom_range(19) != 0);
            trig = ($urandom_range(24) == 0);
            pe   = ($urandom_range(9) < 4);
            if ($urandom_range(49) == 0) mode = ~mode;
            lv   = ($urandom_range(9) == 0);
            data = 16'($urandom);
        end
        @(negedge clk);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
